// File: rtl/fir_pkg.sv
// fir_pkg: shared constants, FSM state type and the power-on coefficient set
// for the 64-tap time-multiplexed FIR engine.
// Optional feature macro: FIR_SAT_EN (output saturation instead of wrap).
package fir_pkg;

  localparam int TAPS    = 64;
  localparam int DATA_W  = 16;
  localparam int COEF_W  = 16;
  localparam int ACC_W   = 38;
  localparam int ADDR_W  = $clog2(TAPS);
  localparam int Q_SHIFT = 15;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    MAC,
    DONE
  } fir_state_e;

  // Symmetric low-pass set, Q1.15, loaded into the coefficient bank on reset.
  localparam logic signed [COEF_W-1:0] FIR_COEFS [TAPS] = '{
    -16'sd12,   -16'sd18,   -16'sd24,   -16'sd28,   -16'sd30,   -16'sd26,   -16'sd16,    16'sd0,
     16'sd22,    16'sd48,    16'sd74,    16'sd96,    16'sd108,   16'sd104,   16'sd80,    16'sd32,
    -16'sd40,   -16'sd132,  -16'sd236,  -16'sd340,  -16'sd428,  -16'sd480,  -16'sd476,  -16'sd396,
    -16'sd224,   16'sd46,    16'sd410,   16'sd860,   16'sd1376,  16'sd1932,  16'sd2490,  16'sd3000,
     16'sd3000,  16'sd2490,  16'sd1932,  16'sd1376,  16'sd860,   16'sd410,   16'sd46,   -16'sd224,
    -16'sd396,  -16'sd476,  -16'sd480,  -16'sd428,  -16'sd340,  -16'sd236,  -16'sd132,  -16'sd40,
     16'sd32,    16'sd80,    16'sd104,   16'sd108,   16'sd96,    16'sd74,    16'sd48,    16'sd22,
     16'sd0,    -16'sd16,   -16'sd26,   -16'sd30,   -16'sd28,   -16'sd24,   -16'sd18,   -16'sd12
  };

endpackage

// File: rtl/fir_delay_line.sv
// fir_delay_line: circular sample history for the FIR engine. A write stores
// the new sample at wptr, remembers that slot as the newest (base) and advances
// wptr. Reads address the sample k steps older than base, so the engine walks
// k = 0..TAPS-1 without moving any data. Async reset clears every entry, which
// is what makes missing history read as zero.
module fir_delay_line #(
  parameter int TAPS   = 64,
  parameter int DATA_W = 16,
  localparam int AW    = $clog2(TAPS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic signed [DATA_W-1:0] wr_data,
  input  logic        [AW-1:0]     rd_k_i,
  output logic signed [DATA_W-1:0] rd_data_o,
  output logic        [AW-1:0]     base
);
  import fir_pkg::*;

  logic signed [DATA_W-1:0] mem_q [TAPS];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] base_q, base_d;
  logic [AW-1:0] rd_idx;

  // Pointer bookkeeping; AW-bit arithmetic gives the mod-TAPS wrap for free.
  always_comb begin
    wptr_d = wptr_q;
    base_d = base_q;
    if (wr_en) begin
      wptr_d = wptr_q + 1'b1;
      base_d = wptr_q;
    end
  end

  // Sample storage and pointers, cleared on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < TAPS; i++) mem_q[i] <= '0;
      wptr_q <= '0;
      base_q <= '0;
    end else begin
      if (wr_en) mem_q[wptr_q] <= wr_data;
      wptr_q <= wptr_d;
      base_q <= base_d;
    end
  end

  // Asynchronous tap read so the MAC can consume one tap per cycle.
  always_comb begin
    rd_idx    = base_q - rd_k_i;
    rd_data_o = mem_q[rd_idx];
  end

  assign base = base_q;

endmodule

// File: rtl/fir_mac_engine.sv
// fir_mac_engine: pops one sample from the upstream FIFO, pushes it into the
// delay line, runs TAPS single-cycle multiply-accumulates and offers the
// Q15-scaled result on a valid/ready port.
// Optional feature macro: FIR_SAT_EN -- when defined the output saturates to
// the DATA_W range, otherwise the low DATA_W bits of the shifted sum are kept.
module fir_mac_engine #(
  parameter int TAPS   = 64,
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int ACC_W  = 38,
  localparam int AW    = $clog2(TAPS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     fifo_empty,
  output logic                     fifo_rd,
  input  logic signed [DATA_W-1:0] fifo_data,
  input  logic                     coef_we,
  input  logic        [AW-1:0]     coef_addr,
  input  logic signed [COEF_W-1:0] coef_wdata,
  output logic signed [DATA_W-1:0] y_data,
  output logic                     y_valid,
  input  logic                     y_ready,
  output logic                     busy
);
  import fir_pkg::*;

  localparam int PROD_W = DATA_W + COEF_W;
  localparam logic [AW-1:0] K_LAST = AW'(TAPS - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX =
    $signed({{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}});
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    $signed({{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}});

  fir_state_e state_q, state_d;
  logic [AW-1:0] k_q, k_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [COEF_W-1:0] h_q [TAPS];

  logic                     dl_wr;
  logic signed [DATA_W-1:0] dl_rd_data;
  logic        [AW-1:0]     dl_base;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  acc_sh;

  fir_delay_line #(
    .TAPS   (TAPS),
    .DATA_W (DATA_W)
  ) u_delay_line (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (dl_wr),
    .wr_data   (fifo_data),
    .rd_k_i    (k_q),
    .rd_data_o (dl_rd_data),
    .base      (dl_base)
  );

  // Full-precision product of the current tap, sign-extended into the accumulator width.
  always_comb begin
    prod     = dl_rd_data * h_q[k_q];
    prod_ext = $signed({{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod});
  end

  // Sequencer: next state, tap counter, accumulator and FIFO/delay-line strobes.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    acc_d   = acc_q;
    fifo_rd = 1'b0;
    dl_wr   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) state_d = FETCH;
      end
      FETCH: begin
        fifo_rd = 1'b1;
        state_d = LOAD;
      end
      LOAD: begin
        // FIFO read data is valid this cycle, one edge after the pop.
        dl_wr   = 1'b1;
        acc_d   = '0;
        k_d     = '0;
        state_d = MAC;
      end
      MAC: begin
        acc_d = acc_q + prod_ext;
        k_d   = k_q + 1'b1;
        if (k_q == K_LAST) state_d = DONE;
      end
      DONE: begin
        if (y_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM, tap counter and accumulator registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
    end
  end

  // Coefficient bank; writes only land in IDLE so a running sum never sees a change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < TAPS; i++) h_q[i] <= FIR_COEFS[i];
    end else if (coef_we && (state_q == IDLE)) begin
      h_q[coef_addr] <= coef_wdata;
    end
  end

  // Output scaling: drop the Q15 fraction, then saturate or wrap into DATA_W.
  always_comb begin
    acc_sh = acc_q >>> Q_SHIFT;
`ifdef FIR_SAT_EN
    if (acc_sh > SAT_MAX)      y_data = SAT_MAX[DATA_W-1:0];
    else if (acc_sh < SAT_MIN) y_data = SAT_MIN[DATA_W-1:0];
    else                       y_data = acc_sh[DATA_W-1:0];
`else
    y_data = acc_sh[DATA_W-1:0];
`endif
  end

  assign y_valid = (state_q == DONE);
  assign busy    = (state_q != IDLE);

  // dl_base is exported for debug visibility; the read path uses it internally.
  logic unused_base;
  assign unused_base = ^dl_base;

endmodule

// File: tb/tb_fir_mac_engine.sv
// Self-checking bench for fir_mac_engine: FIFO model, reference FIR model with
// an expected-result queue, impulse vector table and hand-written corner cases.
module tb_fir_mac_engine;
  import fir_pkg::*;

  logic               clk = 1'b0;
  logic               rst;
  logic               fifo_empty;
  logic               fifo_rd;
  logic signed [15:0] fifo_data;
  logic               coef_we;
  logic        [5:0]  coef_addr;
  logic signed [15:0] coef_wdata;
  logic signed [15:0] y_data;
  logic               y_valid;
  logic               y_ready;
  logic               busy;

  fir_mac_engine dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_empty (fifo_empty),
    .fifo_rd    (fifo_rd),
    .fifo_data  (fifo_data),
    .coef_we    (coef_we),
    .coef_addr  (coef_addr),
    .coef_wdata (coef_wdata),
    .y_data     (y_data),
    .y_valid    (y_valid),
    .y_ready    (y_ready),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic signed [15:0] x;
    logic signed [15:0] y;
  } vec_t;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int fetch_cyc = 0;

  logic signed [15:0] fifo_mem [0:1023];
  int push_cnt = 0;
  int pop_cnt  = 0;
  assign fifo_empty = (push_cnt == pop_cnt);

  int mh    [64];
  int mline [64];
  int mwptr;
  logic signed [15:0] exp_q [$];
  logic signed [15:0] got [0:127];
  int   n_got;
  logic prev_valid;
  vec_t vecs [65];

`ifdef FIR_SAT_EN
  localparam int SAT_EXP = 32767;
`else
  // 64 * 32767 * 32767 >>> 15 = 2097024 = 0x1FFF80; low 16 bits 0xFF80.
  localparam int SAT_EXP = -128;
`endif

  function automatic logic signed [15:0] model_narrow(input longint acc);
    longint sh;
    sh = acc >>> 15;
`ifdef FIR_SAT_EN
    if (sh > 32767)  return 16'sh7fff;
    if (sh < -32768) return 16'sh8000;
`endif
    return 16'(sh);
  endfunction

  task automatic check(input string name, input longint act, input longint expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Runs at a negedge: acts on the DUT outputs seen this cycle, then advances one clock.
  task automatic tick();
    longint sum;
    logic signed [15:0] e;
    if (fifo_rd) begin
      check("pop_not_empty", fifo_empty, 0);
      fifo_data = fifo_mem[pop_cnt];
      pop_cnt++;
      mline[mwptr] = fifo_data;
      sum = 0;
      for (int k = 0; k < 64; k++) sum += longint'(mline[(mwptr - k) & 63]) * longint'(mh[k]);
      mwptr = (mwptr + 1) & 63;
      exp_q.push_back(model_narrow(sum));
      fetch_cyc = cyc;
    end
    if (y_valid && !prev_valid) check("latency", cyc - fetch_cyc, 66);
    prev_valid = y_valid;
    if (y_valid && y_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output: got %0d with no expected entry", y_data);
      end else begin
        e = exp_q.pop_front();
        check("scoreboard_y", y_data, e);
      end
      if (n_got < 128) got[n_got] = y_data;
      n_got++;
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic push(input logic signed [15:0] v);
    fifo_mem[push_cnt] = v;
    push_cnt++;
  endtask

  task automatic write_coef(input int k, input int v, input bit taken);
    coef_we    = 1'b1;
    coef_addr  = 6'(k);
    coef_wdata = 16'(v);
    tick();
    coef_we = 1'b0;
    if (taken) mh[k] = v;
  endtask

  task automatic wait_outputs(input int target, input int budget);
    int n = 0;
    while (n_got < target && n < budget) begin
      tick();
      n++;
    end
    check("outputs_received", n_got, target);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || !fifo_empty) && n < 10000) begin
      tick();
      n++;
    end
    check("idle_reached", busy, 0);
  endtask

  task automatic wait_fetch();
    int n = 0;
    while (!fifo_rd && n < 200) begin
      tick();
      n++;
    end
    check("fetch_seen", fifo_rd, 1);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    #1;
    check("rst_fifo_rd", fifo_rd, 0);
    check("rst_y_valid", y_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_y_data", y_data, 0);
    for (int i = 0; i < 64; i++) begin
      mline[i] = 0;
      mh[i]    = int'(FIR_COEFS[i]);
    end
    mwptr      = 0;
    prev_valid = 1'b0;
    exp_q.delete();
    @(negedge clk);
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int rd_cnt, bad_stable, rd_stall;
    logic signed [15:0] hold;

    for (int i = 0; i < 65; i++) begin
      vecs[i].x = (i == 0) ? 16'sd16384 : 16'sd0;
      vecs[i].y = (i < 64) ? 16'(50 * (i + 1)) : 16'sd0;
    end

    rst        = 1'b1;
    coef_we    = 1'b0;
    coef_addr  = '0;
    coef_wdata = '0;
    fifo_data  = '0;
    y_ready    = 1'b1;
    prev_valid = 1'b0;
    n_got      = 0;
    @(negedge clk);
    apply_reset();

    // Idle with an empty FIFO: nothing moves.
    rd_cnt = 0;
    repeat (100) begin
      if (fifo_rd) rd_cnt++;
      tick();
    end
    check("idle_no_pop", rd_cnt, 0);
    check("idle_y_valid", y_valid, 0);
    check("idle_busy", busy, 0);
    check("idle_y_data", y_data, 0);

    // Impulse response against the vector table.
    for (int k = 0; k < 64; k++) write_coef(k, 100 * (k + 1), 1'b1);
    for (int i = 0; i < 65; i++) push(vecs[i].x);
    n_got = 0;
    wait_outputs(65, 65 * 70 + 100);
    for (int i = 0; i < 65; i++) check("impulse_y", got[i], vecs[i].y);

    // Coefficient write during MAC is dropped; the same write in IDLE lands.
    wait_idle();
    n_got = 0;
    push(16'sd16384);
    push(16'sd16384);
    wait_fetch();
    tick();
    repeat (3) tick();
    check("in_mac", busy, 1);
    write_coef(0, 0, 1'b0);
    wait_outputs(2, 200);
    check("mac_write_ignored_y0", got[0], 50);
    check("mac_write_ignored_y1", got[1], 150);
    wait_idle();
    write_coef(0, 0, 1'b1);
    push(16'sd16384);
    wait_outputs(3, 100);
    check("idle_write_taken_y2", got[2], 250);

    // Saturation / wrap with full-scale samples and coefficients.
    wait_idle();
    for (int k = 0; k < 64; k++) write_coef(k, 32767, 1'b1);
    for (int i = 0; i < 64; i++) push(16'sd32767);
    n_got = 0;
    wait_outputs(64, 64 * 70 + 100);
    check("sat_y64", got[63], SAT_EXP);

    // Backpressure: result held, no pops while stalled.
    wait_idle();
    y_ready = 1'b0;
    push(16'sd1000);
    push(-16'sd2000);
    begin
      int n = 0;
      while (!y_valid && n < 200) begin
        tick();
        n++;
      end
    end
    check("stall_valid", y_valid, 1);
    hold       = y_data;
    bad_stable = 0;
    rd_stall   = 0;
    repeat (200) begin
      tick();
      if (!y_valid || y_data != hold) bad_stable++;
      if (fifo_rd) rd_stall++;
    end
    check("stall_stable", bad_stable, 0);
    check("stall_no_pop", rd_stall, 0);
    n_got   = 0;
    y_ready = 1'b1;
    tick();
    check("release_idle_busy", busy, 0);
    check("release_idle_valid", y_valid, 0);
    tick();
    check("release_fetch", fifo_rd, 1);
    wait_outputs(2, 200);

    // Reset at MAC k=30, then a clean impulse run.
    wait_idle();
    push(16'sd16384);
    wait_fetch();
    tick();
    repeat (31) tick();
    check("pre_reset_busy", busy, 1);
    apply_reset();
    for (int k = 0; k < 64; k++) write_coef(k, 100 * (k + 1), 1'b1);
    for (int i = 0; i < 4; i++) push(vecs[i].x);
    n_got = 0;
    wait_outputs(4, 4 * 70 + 100);
    for (int i = 0; i < 4; i++) check("post_reset_impulse_y", got[i], vecs[i].y);

    repeat (5) tick();
    check("scoreboard_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
